// File: rtl/mwq_pkg.sv
// Shared definitions for the masked write queue.
// Holds the FSM state encoding, the target field bounds inside the wider
// target register (bits 28..26), the derived field/payload widths, the
// default DEPTH/CNT_W values and the masked-merge helper.
package mwq_pkg;

   localparam int FIELD_HI  = 28;
   localparam int FIELD_LO  = 26;
   localparam int FIELD_W   = FIELD_HI - FIELD_LO + 1;
   // A queued entry holds {data, mask}.
   localparam int PAYLOAD_W = 2 * FIELD_W;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_PAUSED = 2'd2
   } mwq_state_e;

   // Bits with mask=1 take the new data, all others keep their current value.
   function automatic logic [FIELD_W-1:0] merge_bits(
      input logic [FIELD_W-1:0] cur,
      input logic [FIELD_W-1:0] data,
      input logic [FIELD_W-1:0] mask
   );
      return (cur & ~mask) | (data & mask);
   endfunction

endpackage

// File: rtl/mwq_fifo.sv
// Synchronous FIFO holding the buffered {data, mask} write requests.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   push_i, wdata_i     write at tail (caller guarantees not full)
//   pop_i, rdata_o      advance head (caller guarantees not empty); rdata_o
//                       always shows the current head entry
//   flush_i             empties the FIFO at the next edge, overrides push/pop
//   level_o             registered occupancy
//   level_next_o        occupancy after the coming edge
module mwq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [W-1:0]     wdata_i,
   output logic [W-1:0]     rdata_o,
   output logic [LVL_W-1:0] level_o,
   output logic [LVL_W-1:0] level_next_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   // DEPTH is a power of two, so pointers wrap naturally on overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (rst_i || flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push_i) - LVL_W'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: level gates every read.
   always_ff @(posedge clk_i) begin
      if (push_i && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o      = mem_q[rd_ptr_q];
   assign level_o      = level_q;
   assign level_next_o = level_d;

endmodule

// File: rtl/masked_write_queue.sv
// Masked write queue: buffers masked write requests and applies them in
// order to a 3-bit slice (bits 28..26) of a target register.
// Ports:
//   clock_0, reset          clock, synchronous active-high reset
//   in_valid/in_ready       request handshake, {in_data, in_mask} payload
//   hold                    stops draining, queue still accepts
//   flush                   discards every buffered request
//   reg_q                   target field value
//   applied_cnt             saturating count of applied non-zero-mask writes
//   level                   FIFO occupancy
//   state                   IDLE=0, DRAIN=1, PAUSED=2
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | queue empty
// ST_DRAIN  | entries buffered, one applied per cycle
// ST_PAUSED | entries buffered, draining suspended by hold
module masked_write_queue
   import mwq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                      clock_0,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [FIELD_W-1:0] in_data,
   input  logic        [FIELD_W-1:0] in_mask,
   input  logic                      hold,
   input  logic                      flush,
   output logic signed [FIELD_W-1:0] reg_q,
   output logic [CNT_W-1:0]          applied_cnt,
   output logic [$clog2(DEPTH):0]    level,
   output logic [1:0]                state
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic                 push;
   logic                 pop;
   logic [PAYLOAD_W-1:0] head;
   logic [FIELD_W-1:0]   head_data;
   logic [FIELD_W-1:0]   head_mask;
   logic [LVL_W-1:0]     level_nxt;

   logic [FIELD_W-1:0]   tgt_q, tgt_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   mwq_state_e           state_q, state_d;

   // No pass-through: a full queue refuses even if a pop happens this cycle.
   assign in_ready = !reset && (level < LVL_W'(DEPTH));
   assign push     = in_valid && in_ready && !flush;
   assign pop      = !reset && !flush && !hold && (level != '0);

   mwq_fifo #(
      .DEPTH (DEPTH),
      .W     (PAYLOAD_W),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk_i        (clock_0),
      .rst_i        (reset),
      .push_i       (push),
      .pop_i        (pop),
      .flush_i      (flush),
      .wdata_i      ({in_data, in_mask}),
      .rdata_o      (head),
      .level_o      (level),
      .level_next_o (level_nxt)
   );

   assign {head_data, head_mask} = head;

   always_comb begin
      tgt_d = tgt_q;
      cnt_d = cnt_q;
      if (pop && (head_mask != '0)) begin
         tgt_d = merge_bits(tgt_q, head_data, head_mask);
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State tracks the occupancy after this edge and the hold level seen now.
   always_comb begin
      state_d = ST_IDLE;
      if (reset || (level_nxt == '0)) state_d = ST_IDLE;
      else if (hold)                  state_d = ST_PAUSED;
      else                            state_d = ST_DRAIN;
   end

   always_ff @(posedge clock_0) begin
      if (reset) begin
         tgt_q   <= '0;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
      end else begin
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign reg_q       = tgt_q;
   assign applied_cnt = cnt_q;
   assign state       = state_q;

endmodule

// File: doc/masked_write_queue.md
MASKED_WRITE_QUEUE -- requirements
Module: masked_write_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered write requests; power of two, 2..16.
REQ-002 Parameter: CNT_W, 8, width of the applied-write counter.
REQ-003 Port: clock_0  input  1  sole clock; all state updates on posedge clock_0.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clock_0.
REQ-005 Port: in_valid  input  1  write request present.
REQ-006 Port: in_ready  output  1  queue can accept a request this cycle.
REQ-007 Port: in_data  input  3  signed write value, bits map to target bits [28:26].
REQ-008 Port: in_mask  input  3  per-bit write enable, 1 = bit written.
REQ-009 Port: hold  input  1  suspends draining; the queue still accepts requests.
REQ-010 Port: flush  input  1  discards all buffered requests.
REQ-011 Port: reg_q  output  3  signed target register value, bits [28:26].
REQ-012 Port: applied_cnt  output  CNT_W  number of applied writes with non-zero mask.
REQ-013 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port: state  output  2  FSM state: IDLE=0, DRAIN=1, PAUSED=2.

Function
REQ-015 in_ready SHALL be high exactly when level < DEPTH and reset is low; there is no pass-through on a full queue.
REQ-016 A push SHALL occur when in_valid && in_ready; {in_data, in_mask} is written at the tail.
REQ-017 A pop SHALL occur when level > 0, hold is low and flush is low.
REQ-018 On a pop, reg_q SHALL become (reg_q & ~mask) | (data & mask) of the head entry at that clock edge.
REQ-019 Latency: a request pushed at edge N SHALL be applied no earlier than edge N+1 and is visible on reg_q after that edge.
REQ-020 Requests SHALL be applied strictly in acceptance order.
REQ-021 A push and a pop in the same cycle SHALL leave level unchanged, and the pushed entry SHALL be retained.
REQ-022 A popped entry with in_mask == 0 SHALL be consumed without changing reg_q or applied_cnt.
REQ-023 applied_cnt SHALL increment by 1 per pop with a non-zero mask and saturate at 2^CNT_W-1.
REQ-024 flush SHALL set level to 0 at the next edge and take priority over a push and a pop in the same cycle; reg_q and applied_cnt are retained.
REQ-025 The FSM state SHALL be IDLE when level == 0, DRAIN when level > 0 and hold is low, and PAUSED when level > 0 and hold is high.
REQ-026 The FSM state SHALL be registered and reflect the next-cycle level and hold values.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH with no loss or duplication of entries.
REQ-028 The block SHALL contain no latches, no multi-clock processes and no asynchronous edges.

Reset
REQ-029 While reset is high: reg_q=0, applied_cnt=0, level=0, state=IDLE, in_ready=0.
REQ-030 reset SHALL override flush, push and pop, and buffered entries are lost.
REQ-031 in_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-032 Shared package mwq_pkg SHALL hold the state encoding, the target field bounds (28, 26), field width 3 and the DEPTH/CNT_W defaults.
REQ-033 The FIFO SHALL be a sub-module mwq_fifo (synchronous, DEPTH entries, 6-bit payload, push/pop/flush, level output).
REQ-034 The top SHALL hold only the FSM, the merge logic for reg_q and the counter.

Verification
REQ-035 After reset, push {data=3'b010, mask=3'b111}, hold=0 -> reg_q=3'b010 one edge after acceptance, applied_cnt=1, state returns to IDLE.
REQ-036 From reg_q=3'b010, push {data=3'b001, mask=3'b110} -> reg_q=3'b000; then push {3'b111, 3'b000} -> reg_q unchanged, applied_cnt unchanged.
REQ-037 With hold=1, push 5 requests with DEPTH=4 -> in_ready low after the 4th push, level=4, state=PAUSED; release hold -> in-order application, level counts down to 0.
REQ-038 At level=4 with hold=0, hold in_valid high continuously -> push and pop alternate with no entry dropped; the final reg_q equals sequential application of all requests.
REQ-039 At level=3 with hold=1, assert flush together with in_valid -> level=0, push ignored, reg_q unchanged; assert reset mid-drain -> all outputs return to their reset values next edge.
REQ-040 Apply 300 non-zero-mask writes with CNT_W=8 -> applied_cnt saturates at 255.
